// File: rtl/datapath_fifo_wr_arbiter.sv
// rtl/datapath_fifo_wr_arbiter.sv - round-robin write arbiter granting beat pairs into the 128->192 datapath FIFO
// Optional macro DP_WR_ARB_THRESH_HOLDOFF_EN: fifo_threshold holds off new arbitration (pairs in flight still finish).
module datapath_fifo_wr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int SRC_IDX_W  = 2,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_threshold,
  output logic                          grant_valid,
  output logic [SRC_IDX_W-1:0]          grant_id,
  output logic [CNT_W-1:0]              pair_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1} state_e;

  state_e               state_q, state_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [SRC_IDX_W-1:0] grant_id_q, grant_id_d;
  logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     pair_count_q, pair_count_d;

  logic                 hold_off;
  logic                 arb_go;
  logic                 xfer;
  logic                 win_found;
  logic [SRC_IDX_W-1:0] win_id;
  logic [SRC_IDX_W:0]   scan_idx;
  logic [SRC_IDX_W-1:0] next_ptr;

`ifdef DP_WR_ARB_THRESH_HOLDOFF_EN
  assign hold_off = fifo_threshold;
`else
  logic unused_threshold;
  assign unused_threshold = fifo_threshold;
  assign hold_off         = 1'b0;
`endif

  assign arb_go   = (|src_valid) & ~fifo_full & ~hold_off;
  assign xfer     = (state_q != ST_IDLE) & src_valid[grant_id_q] & ~fifo_full;
  assign next_ptr = (grant_id_q == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : grant_id_q + SRC_IDX_W'(1);

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_SRC so non-power-of-two counts never produce an illegal id.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (SRC_IDX_W + 1)'(k);
      if (scan_idx >= (SRC_IDX_W + 1)'(NUM_SRC)) begin
        scan_idx = scan_idx - (SRC_IDX_W + 1)'(NUM_SRC);
      end
      if (!win_found && src_valid[scan_idx[SRC_IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[SRC_IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      pair_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      pair_count_q  <= pair_count_d;
    end
  end

  // The grant only moves in IDLE, so both beats of a pair always come from the same source.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    pair_count_d  = pair_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_go && win_found) begin
          state_d       = ST_BEAT0;
          grant_valid_d = 1'b1;
          grant_id_d    = win_id;
        end
      end
      ST_BEAT0: begin
        if (xfer) state_d = ST_BEAT1;
      end
      ST_BEAT1: begin
        if (xfer) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_ptr;
          pair_count_d  = pair_count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    fifo_wr      = xfer;
    src_ready    = '0;
    fifo_data_in = '0;
    if (state_q != ST_IDLE) begin
      src_ready[grant_id_q] = xfer;
      fifo_data_in          = src_data[grant_id_q * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign pair_count  = pair_count_q;

endmodule

// File: tb/tb_datapath_fifo_wr_arbiter.sv
// tb/tb_datapath_fifo_wr_arbiter.sv - directed and randomized checks of the pair write arbiter against a transaction model
module tb_datapath_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   src_valid;
  logic [511:0] src_data;
  logic [3:0]   src_ready;
  logic         fifo_wr;
  logic [127:0] fifo_data_in;
  logic         fifo_full;
  logic         fifo_threshold;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [15:0]  pair_count;

  int n_vec = 0;
  int n_err = 0;

  datapath_fifo_wr_arbiter dut (
    .clk            (clk),
    .rstn           (rstn),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .fifo_wr        (fifo_wr),
    .fifo_data_in   (fifo_data_in),
    .fifo_full      (fifo_full),
    .fifo_threshold (fifo_threshold),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .pair_count     (pair_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] slot(int i);
    return src_data[i*128 +: 128];
  endfunction

  task automatic fill_data();
    for (int i = 0; i < 4; i++) src_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rstn = 1'b0; src_valid = '0; fifo_full = 1'b0; fifo_threshold = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; src_valid = 4'b1111; fifo_full = 1'b0; fifo_threshold = 1'b0; fill_data();
    tick(); tick();
    n_vec++;
    if ({grant_valid, grant_id, pair_count} !== 19'd0) begin
      n_err++; $display("FAIL reset_regs: got gv/id/cnt=%h expected 0", {grant_valid, grant_id, pair_count});
    end
    n_vec++;
    if ({fifo_wr, src_ready, fifo_data_in} !== 133'd0) begin
      n_err++; $display("FAIL reset_outputs: got wr=%b ready=%b data=%h expected all zero", fifo_wr, src_ready, fifo_data_in);
    end
    rstn = 1'b1; src_valid = '0;
  endtask

  task automatic test_single_source();
    logic [127:0] a, b;
    do_reset(); fill_data(); a = slot(0); src_valid = 4'b0001; #1;
    n_vec++;
    if (fifo_wr !== 1'b0 || grant_valid !== 1'b0) begin
      n_err++; $display("FAIL single_idle: got wr=%b gv=%b expected 0 0", fifo_wr, grant_valid);
    end
    tick();
    n_vec++;
    if ({grant_valid, grant_id, fifo_wr, src_ready} !== {1'b1, 2'd0, 1'b1, 4'b0001} || fifo_data_in !== a) begin
      n_err++; $display("FAIL single_beat0: got gv=%b id=%0d wr=%b rdy=%b data=%h expected 1 0 1 0001 %h", grant_valid, grant_id, fifo_wr, src_ready, fifo_data_in, a);
    end
    tick(); b = {$urandom, $urandom, $urandom, $urandom}; src_data[127:0] = b; #1;
    n_vec++;
    if (fifo_wr !== 1'b1 || fifo_data_in !== b) begin
      n_err++; $display("FAIL single_beat1: got wr=%b data=%h expected 1 %h", fifo_wr, fifo_data_in, b);
    end
    tick(); src_valid = '0; #1;
    n_vec++;
    if ({pair_count, grant_valid, fifo_wr} !== {16'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_done: got cnt=%0d gv=%b wr=%b expected 1 0 0", pair_count, grant_valid, fifo_wr);
    end
  endtask

  task automatic test_rotation();
    do_reset(); src_valid = 4'b1111; fill_data();
    for (int p = 0; p < 8; p++) begin
      tick();
      n_vec++;
      if ({grant_id, fifo_wr, src_ready} !== {2'(p % 4), 1'b1, 4'(1 << (p % 4))} || fifo_data_in !== slot(p % 4)) begin
        n_err++; $display("FAIL rot_beat0 pair %0d: got id=%0d wr=%b rdy=%b expected id=%0d", p, grant_id, fifo_wr, src_ready, p % 4);
      end
      tick(); fill_data(); #1;
      n_vec++;
      if ({grant_id, fifo_wr} !== {2'(p % 4), 1'b1} || fifo_data_in !== slot(p % 4)) begin
        n_err++; $display("FAIL rot_beat1 pair %0d: got id=%0d wr=%b expected id=%0d wr=1", p, grant_id, fifo_wr, p % 4);
      end
      tick();
    end
    n_vec++;
    if (pair_count !== 16'd8) begin
      n_err++; $display("FAIL rot_count: got %0d expected 8", pair_count);
    end
  endtask

  task automatic test_valid_drop();
    do_reset(); fill_data(); src_valid = 4'b0100;
    tick();
    n_vec++;
    if ({grant_id, fifo_wr, src_ready} !== {2'd2, 1'b1, 4'b0100}) begin
      n_err++; $display("FAIL drop_beat0: got id=%0d wr=%b rdy=%b expected 2 1 0100", grant_id, fifo_wr, src_ready);
    end
    tick(); src_valid = 4'b1010; #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if ({grant_valid, grant_id, fifo_wr, src_ready} !== {1'b1, 2'd2, 1'b0, 4'b0000}) begin
        n_err++; $display("FAIL drop_stall cyc %0d: got gv=%b id=%0d wr=%b rdy=%b expected 1 2 0 0000", c, grant_valid, grant_id, fifo_wr, src_ready);
      end
      tick();
    end
    src_valid = 4'b1110; #1;
    n_vec++;
    if ({fifo_wr, src_ready} !== {1'b1, 4'b0100} || fifo_data_in !== slot(2)) begin
      n_err++; $display("FAIL drop_resume: got wr=%b rdy=%b data=%h expected 1 0100 %h", fifo_wr, src_ready, fifo_data_in, slot(2));
    end
    tick();
    n_vec++;
    if ({pair_count, grant_valid} !== {16'd1, 1'b0}) begin
      n_err++; $display("FAIL drop_done: got cnt=%0d gv=%b expected 1 0", pair_count, grant_valid);
    end
  endtask

  task automatic test_full();
    do_reset(); fill_data(); src_valid = 4'b1111; fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if ({grant_valid, fifo_wr} !== 2'b00) begin
        n_err++; $display("FAIL full_idle cyc %0d: got gv=%b wr=%b expected 0 0", c, grant_valid, fifo_wr);
      end
    end
    fifo_full = 1'b0;
    tick();
    n_vec++;
    if ({grant_valid, grant_id, fifo_wr} !== {1'b1, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL full_release: got gv=%b id=%0d wr=%b expected 1 0 1", grant_valid, grant_id, fifo_wr);
    end
    fifo_full = 1'b1; #1;
    n_vec++;
    if ({fifo_wr, src_ready} !== 5'b0) begin
      n_err++; $display("FAIL full_midpair: got wr=%b rdy=%b expected 0 0000", fifo_wr, src_ready);
    end
    tick(); fifo_full = 1'b0; #1;
    n_vec++;
    if ({grant_valid, grant_id, fifo_wr} !== {1'b1, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL full_hold: got gv=%b id=%0d wr=%b expected 1 0 1", grant_valid, grant_id, fifo_wr);
    end
    tick(); tick();
    n_vec++;
    if (pair_count !== 16'd1) begin
      n_err++; $display("FAIL full_count: got %0d expected 1", pair_count);
    end
  endtask

  task automatic test_reset_mid_pair();
    do_reset(); fill_data(); src_valid = 4'b0001;
    repeat (5) tick();
    n_vec++;
    if ({pair_count, fifo_wr} !== {16'd1, 1'b1}) begin
      n_err++; $display("FAIL rmp_pre: got cnt=%0d wr=%b expected 1 1", pair_count, fifo_wr);
    end
    rstn = 1'b0;
    tick();
    n_vec++;
    if ({grant_valid, grant_id, pair_count, fifo_wr} !== 20'd0) begin
      n_err++; $display("FAIL rmp_post: got gv=%b id=%0d cnt=%0d wr=%b expected all 0", grant_valid, grant_id, pair_count, fifo_wr);
    end
    rstn = 1'b1; src_valid = '0;
  endtask

  task automatic test_threshold();
    do_reset(); fill_data(); src_valid = 4'b0100; fifo_threshold = 1'b1;
`ifdef DP_WR_ARB_THRESH_HOLDOFF_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (grant_valid !== 1'b0) begin
        n_err++; $display("FAIL thr_holdoff cyc %0d: got gv=%b expected 0", c, grant_valid);
      end
    end
    fifo_threshold = 1'b0;
    tick(); fifo_threshold = 1'b1; #1;
    n_vec++;
    if ({grant_valid, grant_id, fifo_wr} !== {1'b1, 2'd2, 1'b1}) begin
      n_err++; $display("FAIL thr_beat0: got gv=%b id=%0d wr=%b expected 1 2 1", grant_valid, grant_id, fifo_wr);
    end
    tick();
`else
    tick();
    n_vec++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd2}) begin
      n_err++; $display("FAIL thr_ignored: got gv=%b id=%0d expected 1 2", grant_valid, grant_id);
    end
    tick();
`endif
    n_vec++;
    if (fifo_wr !== 1'b1) begin
      n_err++; $display("FAIL thr_beat1: got wr=%b expected 1", fifo_wr);
    end
    tick();
    n_vec++;
    if (pair_count !== 16'd1) begin
      n_err++; $display("FAIL thr_count: got %0d expected 1", pair_count);
    end
    fifo_threshold = 1'b0;
  endtask

  // Transaction model: owner of the current pair, beats it has delivered, next priority, completed pairs.
  task automatic test_random();
    int owner = -1, beats = 0, rr = 0, pairs = 0, last = 0;
    bit hold, x, found;
    logic [3:0]   e_rdy;
    logic [127:0] e_data;
    logic [151:0] got, exp_v;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rstn = ($urandom_range(0, 49) != 0);
      src_valid = 4'($urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 4) == 0);
      fifo_threshold = ($urandom_range(0, 3) == 0);
      fill_data(); #1;
`ifdef DP_WR_ARB_THRESH_HOLDOFF_EN
      hold = fifo_threshold;
`else
      hold = 1'b0;
`endif
      x = 1'b0; e_rdy = '0; e_data = '0;
      if (owner >= 0) begin
        x = src_valid[owner] && !fifo_full;
        e_rdy[owner] = x;
        e_data = slot(owner);
      end
      exp_v = {owner >= 0, 2'(last), 16'(pairs), x, e_rdy, e_data};
      got   = {grant_valid, grant_id, pair_count, fifo_wr, src_ready, fifo_data_in};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL random cyc %0d: got gv/id/cnt/wr/rdy/data=%h expected %h", cyc, got, exp_v);
      end
      if (!rstn) begin
        owner = -1; beats = 0; rr = 0; pairs = 0; last = 0;
      end else if (owner < 0) begin
        if (src_valid != 0 && !fifo_full && !hold) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if (!found && src_valid[(rr + k) % 4]) begin
              found = 1'b1; owner = (rr + k) % 4;
            end
          end
          last = owner; beats = 0;
        end
      end else if (x) begin
        beats++;
        if (beats == 2) begin
          pairs = (pairs + 1) % 65536; rr = (owner + 1) % 4; owner = -1;
        end
      end
      tick();
    end
    rstn = 1'b1;
  endtask

  initial begin
    src_data = '0;
    test_reset();
    test_single_source();
    test_rotation();
    test_valid_drop();
    test_full();
    test_reset_mid_pair();
    test_threshold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
